// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM states and command codes for the SPI RAM slave
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_p.sv
// rtl/spi_ram_p.sv - single-port RAM with write/read address registers driven by decoded frames
module spi_ram_p
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  rd_addr_valid
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;

  assign cmd     = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = rx_data[DATA_WIDTH-1:0];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Memory array and read port carry no reset; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CMD_WR_DATA) mem[wr_addr] <= payload;
    if (rx_valid && cmd == CMD_RD_DATA) tx_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr       <= '0;
      rd_addr       <= '0;
      rd_addr_valid <= 1'b0;
      tx_valid      <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload[ADDR_WIDTH-1:0];
          CMD_WR_DATA: if (AUTO_INC != 0) wr_addr <= next_addr(wr_addr);
          CMD_RD_ADDR: begin
            rd_addr       <= payload[ADDR_WIDTH-1:0];
            rd_addr_valid <= 1'b1;
          end
          default: begin
            tx_valid <= 1'b1;
            // Streaming mode keeps the address live so read-data frames can follow back to back.
            if (AUTO_INC != 0) rd_addr <= next_addr(rd_addr);
            else               rd_addr_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_slave_ram_p.sv
// rtl/spi_slave_ram_p.sv - SPI mode-0 slave: frame FSM, shift-in, MISO serializer, frame check
module spi_slave_ram_p
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int FRAME_BITS = DATA_WIDTH + 2;
  localparam int CW         = $clog2(FRAME_BITS + 1);
  localparam int TCW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] FULL     = CW'(FRAME_BITS);

  state_t                state, state_n;
  logic [CW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] rx_sh;
  logic                  rx_valid;
  logic [1:0]            cmd_in;
  logic                  shifting, last_bit, bad_cmd;
  logic [DATA_WIDTH-1:0] tx_data, tx_sh;
  logic                  tx_valid;
  logic [TCW-1:0]        tx_cnt;
  logic                  rd_addr_valid;

  assign busy     = (state != IDLE);
  assign shifting = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA)
                    && bit_cnt != FULL;
  assign last_bit = shifting && bit_cnt == LAST_BIT;
  // On the last bit the command still sits one position below the frame MSB.
  assign cmd_in   = rx_sh[DATA_WIDTH:DATA_WIDTH-1];

  always_comb begin
    state_n = state;
    bad_cmd = 1'b0;
    case (state)
      IDLE:      state_n = CHK_CMD;
      CHK_CMD:   state_n = MOSI ? (rd_addr_valid ? READ_DATA : READ_ADD) : WRITE;
      WRITE:     bad_cmd = cmd_in[1];
      READ_ADD:  bad_cmd = (cmd_in != CMD_RD_ADDR);
      READ_DATA: bad_cmd = !cmd_in[1];
      default:   state_n = IDLE;
    endcase
    if (SS_n) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= last_bit && !bad_cmd;
      frame_err <= last_bit && bad_cmd;
      if (SS_n) begin
        bit_cnt <= '0;
      end else if (shifting) begin
        rx_sh   <= {rx_sh[FRAME_BITS-2:0], MOSI};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO   <= 1'b0;
      tx_sh  <= '0;
      tx_cnt <= '0;
    end else if (SS_n) begin
      MISO   <= 1'b0;
      tx_cnt <= '0;
    end else if (tx_valid) begin
      MISO   <= tx_data[DATA_WIDTH-1];
      tx_sh  <= {tx_data[DATA_WIDTH-2:0], 1'b0};
      tx_cnt <= TCW'(DATA_WIDTH - 1);
    end else if (tx_cnt != '0) begin
      MISO   <= tx_sh[DATA_WIDTH-1];
      tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      MISO   <= 1'b0;
    end
  end

  spi_ram_p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .AUTO_INC  (AUTO_INC)
  ) u_ram (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_sh),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .rd_addr_valid(rd_addr_valid)
  );

endmodule
